serial_alu_ctrl: RTL

Bit-serial ALU sequencer that drives the existing `alu1bit` slice for one bit per cycle to execute a full WIDTH-bit ADD, SUB, AND, OR or XOR. It captures operands on a start handshake, walks the slice from LSB to MSB while holding the inter-bit carry, assembles the result and reports carry, overflow and zero flags. It serves as the area-minimal execute unit for the 5-stage core's multi-cycle and debug paths.

---
 rtl/serial_alu_ctrl_pkg.sv | 26 ++
 rtl/serial_alu_ctrl_alu1bit.sv | 24 ++
 rtl/serial_alu_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_alu_ctrl_pkg.sv
// Shared op and state encodings for the bit-serial ALU and the decode stage.
package serial_alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_alu1bit.sv
// One-bit ALU slice: full adder with optional B inversion plus bitwise AND/OR/XOR.
// Purely combinational, no flow control.
module alu1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry,
  input  logic i_sub,
  output logic o_add,
  output logic o_and,
  output logic o_or,
  output logic o_xor,
  output logic o_carry
);

  logic w_b;

  assign w_b     = i_b ^ i_sub;
  assign o_add   = i_a ^ w_b ^ i_carry;
  assign o_carry = (i_a & w_b) | (i_a & i_carry) | (w_b & i_carry);
  assign o_and   = i_a & i_b;
  assign o_or    = i_a | i_b;
  assign o_xor   = i_a ^ i_b;

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial WIDTH-bit ALU sequencer: LSB-first through one alu1bit slice, done WIDTH+1 cycles after accept.
// Flow control: start is taken only while ready; requests during RUN/DONE are dropped.
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res_sr;
  logic [WIDTH-1:0] w_res_nxt;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_cy;
  logic             w_accept;
  logic             w_last;
  logic             w_sel;
  logic             w_add;
  logic             w_and;
  logic             w_or;
  logic             w_xor;
  logic             w_cout;

  alu1bit u_slice (
    .i_a     (r_a_sr[0]),
    .i_b     (r_b_sr[0]),
    .i_carry (r_cy),
    .i_sub   (r_op == OP_SUB),
    .o_add   (w_add),
    .o_and   (w_and),
    .o_or    (w_or),
    .o_xor   (w_xor),
    .o_carry (w_cout)
  );

  always_comb begin
    w_sel = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: w_sel = w_add;
      OP_AND:         w_sel = w_and;
      OP_OR:          w_sel = w_or;
      OP_XOR:         w_sel = w_xor;
      default:        w_sel = 1'b0;
    endcase
  end

  assign w_res_nxt = {w_sel, r_res_sr};
  assign w_accept  = ready & start;
  assign w_last    = busy & (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = op_is_legal(op) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Flags are registered on the final RUN edge so they appear together with done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_cy     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_res_sr <= '0;
      r_op     <= op;
      r_cnt    <= '0;
      r_cy     <= (op == OP_SUB);
      if (!op_is_legal(op)) begin
        result   <= '0;
        carry    <= 1'b0;
        overflow <= 1'b0;
        zero     <= 1'b0;
        illegal  <= 1'b1;
      end
    end else if (busy) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res_sr <= w_res_nxt[WIDTH-1:1];
      r_cy     <= w_cout;
      r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last) begin
        result   <= w_res_nxt;
        carry    <= op_is_arith(r_op) & w_cout;
        overflow <= op_is_arith(r_op) & (r_cy ^ w_cout);
        zero     <= (w_res_nxt == '0);
        illegal  <= 1'b0;
      end
    end
  end

endmodule
